// File: rtl/tt_um_urish_silife.sv
// ---------------------------------------------------------------------------
// tt_um_urish_silife
//   Conway's Game of Life engine on a fixed 8x8 grid, packaged as a
//   TinyTapeout user module. The host loads rows through uio_in, reads any
//   row back on uo_out, and with en held high the grid advances one
//   generation (B3/S23) per clock. Cells outside the grid count as dead;
//   there is no wrap-around.
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst_n    asynchronous active-low reset, clears every cell
//   ena      TinyTapeout design-select, ignored
//   ui_in    [7]=wr_en, [6]=en, [5:3] unused, [2:0]=row_select
//   uo_out   contents of row row_select (bit c = column c, 1 = alive)
//   uio_in   row data written when wr_en=1 (bit c = column c)
//   uio_out  constant 0
//   uio_oe   constant 0, all uio pins are inputs
// ---------------------------------------------------------------------------
module tt_um_urish_silife (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Population count of the eight neighbour bits, result range 0..8.
  function automatic logic [3:0] count_neighbours(input logic [7:0] bits);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'd0, bits[i]};
    end
    return sum;
  endfunction

  // B3/S23: birth on exactly three, survival on two or three.
  function automatic logic life_rule(input logic self, input logic [3:0] n);
    return (n == 4'd3) || (self && (n == 4'd2));
  endfunction

  logic       wr_en_s;
  logic       en_s;
  logic [2:0] row_sel_s;

  logic [7:0][7:0] grid_r;   // grid_r[r][c] = cell at row r, column c
  logic [7:0][7:0] next_s;   // next generation of every cell
  logic [9:0][9:0] pad_s;    // grid framed by a ring of dead cells

  logic unused_s;

  assign wr_en_s   = ui_in[7];
  assign en_s      = ui_in[6];
  assign row_sel_s = ui_in[2:0];

  // Pins that are deliberately ignored are folded into one sink signal.
  assign unused_s = &{1'b0, ena, ui_in[5:3]};

  // Frame the grid with dead cells so edge cells see zeros outside the board.
  always_comb begin
    pad_s = 100'd0;
    for (int r = 0; r < 8; r++) begin
      pad_s[r + 1] = {1'b0, grid_r[r], 1'b0};
    end
  end

  // Per-cell neighbour count and rule; pad_s[r+1][c+1] is the cell itself.
  always_comb begin
    next_s = 64'd0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        next_s[r][c] = life_rule(grid_r[r][c],
                                 count_neighbours({pad_s[r][c],     pad_s[r][c + 1],     pad_s[r][c + 2],
                                                   pad_s[r + 1][c],                      pad_s[r + 1][c + 2],
                                                   pad_s[r + 2][c], pad_s[r + 2][c + 1], pad_s[r + 2][c + 2]}));
      end
    end
  end

  // Cell state: async clear, write beats step, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid_r <= 64'd0;
    end else if (wr_en_s) begin
      grid_r[row_sel_s] <= uio_in;
    end else if (en_s) begin
      grid_r <= next_s;
    end else begin
      grid_r <= grid_r;
    end
  end

  // Row read mux is combinational so a write or step shows right after the edge.
  assign uo_out  = grid_r[row_sel_s];
  assign uio_out = 8'd0;
  assign uio_oe  = 8'd0;

endmodule

// File: tb/tb_tt_um_urish_silife.sv
// ---------------------------------------------------------------------------
// tb_tt_um_urish_silife
//   Self-checking bench for tt_um_urish_silife. Expected row values are
//   pushed to a scoreboard queue, then each row is selected on ui_in[2:0],
//   the entry popped and compared against uo_out.
// ---------------------------------------------------------------------------
module tb_tt_um_urish_silife;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total_cnt;
  int bad_cnt;

  typedef struct {
    string      tag;
    logic [2:0] sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];

  tt_um_urish_silife dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before anything is sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [2:0] r, input logic [7:0] v);
    ui_in  = {1'b1, 1'b0, 3'b000, r};
    uio_in = v;
    tick();
    ui_in  = 8'h00;
    uio_in = 8'h00;
  endtask

  task automatic load_grid(input logic [63:0] rows);
    for (int r = 0; r < 8; r++) begin
      write_row(r[2:0], rows[r*8 +: 8]);
    end
  endtask

  task automatic step(input int n);
    ui_in = 8'h40;
    repeat (n) tick();
    ui_in = 8'h00;
  endtask

  // rows is {row7, ..., row0}; push all eight, then pop and compare each.
  task automatic expect_grid(input string tag, input logic [63:0] rows);
    exp_t e;
    for (int r = 0; r < 8; r++) begin
      e.tag = $sformatf("%s_row%0d", tag, r);
      e.sel = r[2:0];
      e.val = rows[r*8 +: 8];
      sb_q.push_back(e);
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      ui_in = {5'b00000, e.sel};
      #1;
      check_eq(e.tag, uo_out, e.val);
    end
    ui_in = 8'h00;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    ena       = 1'b1;
    ui_in     = 8'h00;
    uio_in    = 8'h00;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    expect_grid("reset", 64'h0000_0000_0000_0000);
    check_eq("reset_uio_oe", uio_oe, 8'h00);
    check_eq("reset_uio_out", uio_out, 8'h00);

    // Write / readback with walking one, then idle hold
    load_grid(64'h8040_2010_0804_0201);
    expect_grid("wr", 64'h8040_2010_0804_0201);
    repeat (10) tick();
    expect_grid("idle", 64'h8040_2010_0804_0201);

    // Blinker oscillates with period two
    load_grid(64'h0000_0000_001C_0000);
    step(1);
    expect_grid("blink1", 64'h0000_0000_0808_0800);
    step(1);
    expect_grid("blink2", 64'h0000_0000_001C_0000);

    // Block still life
    load_grid(64'h0000_0018_1800_0000);
    step(5);
    expect_grid("block", 64'h0000_0018_1800_0000);

    // Top edge does not wrap to row 7
    load_grid(64'h0000_0000_0000_0007);
    step(1);
    expect_grid("edge1", 64'h0000_0000_0000_0202);
    step(1);
    expect_grid("edge2", 64'h0000_0000_0000_0000);

    // Write beats step when both are requested
    load_grid(64'h0000_0000_001C_0000);
    ui_in  = {1'b1, 1'b1, 3'b000, 3'd5};
    uio_in = 8'hFF;
    tick();
    ui_in  = 8'h00;
    uio_in = 8'h00;
    expect_grid("prio", 64'h0000_FF00_001C_0000);

    // Asynchronous reset clears immediately, between edges
    ui_in = 8'h05;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_row5", uo_out, 8'h00);
    ui_in = 8'h02;
    #1;
    check_eq("async_rst_row2", uo_out, 8'h00);
    check_eq("async_rst_uio_oe", uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    ui_in = 8'h00;
    tick();
    expect_grid("post_rst", 64'h0000_0000_0000_0000);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/tt_um_urish_silife.md
Name: tt_um_urish_silife

Overview:
- Hardware Conway's Game of Life ("silicon life") engine on an 8x8 cell grid, packaged as a TinyTapeout user module.
- The host writes grid rows through the bidirectional pins and reads any row back on the dedicated outputs.
- With the enable input held high, the grid advances one generation per clock.

Parameters:
- None. Grid is fixed at 8 rows x 8 columns.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  TinyTapeout design-select; ignored, design operates regardless
- ui_in  input  8  control: [7]=wr_en, [6]=en, [5:3] unused (ignored), [2:0]=row_select
- uo_out  output  8  grid_out: contents of row row_select, bit c = column c (1 = alive)
- uio_in  input  8  grid_in: row data written when wr_en=1, bit c = column c
- uio_out  output  8  constant 0
- uio_oe  output  8  constant 0 (all uio pins are inputs)

Behaviour:
- State: 64 cell flops cell[r][c], r,c in 0..7. Row r is an 8-bit word.
- Reset (rst_n=0, asynchronous): all cells cleared to 0 immediately; held while rst_n=0. Deassertion is clean; the first update occurs on the next rising clk.
- Outputs during and after reset: uo_out=0x00 until cells are written; uio_out=0x00 and uio_oe=0x00 always.
- Read path:
  - uo_out = row[row_select], purely combinational from current state and ui_in[2:0]. Zero-cycle latency.
  - Reflects the post-edge state after any write or step.
- Write:
  - On a rising clk with wr_en=1: row[row_select] <= uio_in.
  - All other rows hold.
  - Visible on uo_out immediately after that edge.
- Step:
  - On a rising clk with wr_en=0 and en=1, every cell updates simultaneously from the previous state.
  - n = count of live neighbours among the 8 surrounding cells, range 0..8. Needs a 4-bit count or equivalent.
  - next = 1 if n==3, or if (cell==1 and n==2). Otherwise next = 0 (B3/S23).
- Boundary: non-toroidal. Positions outside rows 0..7 or columns 0..7 count as dead. No wrap-around.
- Simultaneous wr_en=1 and en=1: write has priority. Only the write occurs and no generation step is taken that cycle.
- Idle (wr_en=0, en=0): grid holds indefinitely.
- Reset mid-step or mid-write: asynchronous clear wins. Grid is all-zero afterwards.
- Implementation: 64 neighbour-count/rule instances plus a row-write decoder and an 8:1 row read mux. No FSM.

Test Plan:
- Reset: assert rst_n=0, then release. Read row_select 0..7 -> uo_out=0x00 for each; uio_oe=0x00, uio_out=0x00.
- Write/readback: write rows 0..7 with 0x01,0x02,0x04,...,0x80 (wr_en=1, en=0, one clk each). Read each row -> same values, other rows unaffected. Idle 10 clocks -> unchanged.
- Blinker:
  - Write row2=0x1C, all others 0.
  - One clk with en=1 -> rows1,2,3=0x08, others 0x00.
  - Second step -> row2=0x1C, rows1,3=0x00.
- Still life: write rows3,4=0x18. Step 5 generations -> rows3,4 remain 0x18, others 0x00.
- Dead boundary (non-wrap):
  - Write row0=0x07, others 0.
  - Step once -> row0=0x02, row1=0x02, row7=0x00.
  - Step again -> all rows 0x00.
- Priority and async reset:
  - Load blinker (row2=0x1C). Drive wr_en=1, en=1, row_select=5, uio_in=0xFF for one clk -> row5=0xFF, row2 still 0x1C (no step taken).
  - Then pull rst_n low between clock edges -> uo_out=0x00 immediately, without a clk edge.
